// File: rtl/caiji_multi.sv
// caiji_multi: per-frame sum of a selected RGB565 channel at NPTS cycle offsets, aligned to vs falling edges
module caiji_multi #(
  parameter int NPTS = 5,
  parameter int CNT_W = 21,
  parameter logic [NPTS*CNT_W-1:0] OFFS = {21'd304360, 21'd305000, 21'd562728, 21'd820456, 21'd821096},
  parameter int FRAME_CYC = 1075200,
  parameter int NFRAMES = 601,
  parameter int FCNT_W = 12,
  parameter int SUM_W = 9,
  parameter bit RESYNC = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key,
  input  logic              vs,
  input  logic [15:0]       vout_data,
  input  logic [1:0]        chan_sel,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  output logic              vs_s,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt
);
  typedef enum logic [2:0] {IDLE, ARM, RUN, WAIT_VS, DONE} state_t;
  state_t state, state_n;
  logic vs_d, vs_fall, hit, last;
  logic [1:0] sel_q;
  logic [CNT_W-1:0] cyc;
  logic [SUM_W-1:0] acc, samp;
  logic [5:0] ch;
  logic [FCNT_W-1:0] fc_inc;
  assign vs_fall = vs_d & ~vs;
  assign last = cyc == CNT_W'(FRAME_CYC - 1);
  assign fc_inc = frame_cnt + FCNT_W'(1);
  assign busy = state == ARM || state == RUN || state == WAIT_VS;
  assign done = state == DONE;
  always_comb begin
    ch = sel_q == 2'd0 ? {1'b0, vout_data[15:11]} :
         sel_q == 2'd1 ? vout_data[10:5] :
         sel_q == 2'd2 ? {1'b0, vout_data[4:0]} :
                         {1'b0, vout_data[15:11]} + {1'b0, vout_data[4:0]};
    samp = SUM_W'(ch);
    hit = 1'b0;
    for (int i = 0; i < NPTS; i++)
      hit = hit | (cyc == OFFS[i*CNT_W +: CNT_W]);
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:         state_n = key ? IDLE : ARM;
      ARM, WAIT_VS: state_n = vs_fall ? RUN : state;
      RUN:          state_n = !last ? RUN : fc_inc == FCNT_W'(NFRAMES) ? DONE : RESYNC ? WAIT_VS : RUN;
      DONE:         state_n = key ? IDLE : DONE;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d <= 1'b0;
      sel_q <= 2'd0;
      cyc <= '0;
      acc <= '0;
      sum_out <= '0;
      sum_valid <= 1'b0;
      vs_s <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_d <= vs;
      sum_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cyc <= '0;
          acc <= '0;
          if (!key) begin
            sel_q <= chan_sel;
            frame_cnt <= '0;
          end
        end
        ARM, WAIT_VS: begin
          cyc <= '0;
          acc <= '0;
          if (vs_fall) vs_s <= 1'b1;
        end
        RUN:
          if (last) begin
            sum_out <= acc + (hit ? samp : '0);
            sum_valid <= 1'b1;
            acc <= '0;
            cyc <= '0;
            frame_cnt <= fc_inc;
          end else begin
            cyc <= cyc + CNT_W'(1);
            if (hit) acc <= acc + samp;
          end
        DONE:
          if (key) vs_s <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_caiji_multi.sv
// tb_caiji_multi: scoreboard bench for free-running and resync instances of caiji_multi
module tb_caiji_multi;
  logic clk = 1'b0;
  logic rst, key_a, key_b, vs;
  logic [15:0] vout_data;
  logic [1:0] chan_sel;
  logic [8:0] sum_out_a, sum_out_b;
  logic sum_valid_a, sum_valid_b, vs_s_a, vs_s_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] frame_cnt_a, frame_cnt_b;
  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int q_a[$], q_b[$], t_a[$], t_b[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  caiji_multi #(.NPTS(3), .CNT_W(5), .OFFS({5'd2, 5'd5, 5'd9}), .FRAME_CYC(16), .NFRAMES(3),
                .FCNT_W(4), .SUM_W(9), .RESYNC(1'b0)) u_a (
    .clk(clk), .rst(rst), .key(key_a), .vs(vs), .vout_data(vout_data), .chan_sel(chan_sel),
    .sum_out(sum_out_a), .sum_valid(sum_valid_a), .vs_s(vs_s_a), .busy(busy_a), .done(done_a),
    .frame_cnt(frame_cnt_a));
  caiji_multi #(.NPTS(3), .CNT_W(5), .OFFS({5'd2, 5'd5, 5'd15}), .FRAME_CYC(16), .NFRAMES(3),
                .FCNT_W(4), .SUM_W(9), .RESYNC(1'b1)) u_b (
    .clk(clk), .rst(rst), .key(key_b), .vs(vs), .vout_data(vout_data), .chan_sel(chan_sel),
    .sum_out(sum_out_b), .sum_valid(sum_valid_b), .vs_s(vs_s_b), .busy(busy_b), .done(done_b),
    .frame_cnt(frame_cnt_b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? sum_valid_a : w == 1 ? sum_valid_b : done_a;
  endfunction
  task automatic wait_for(input int w);
    int n = 0;
    while (!sig(w) && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("wait_%0d", w), sig(w), 1);
  endtask
  always @(negedge clk) begin
    if (sum_valid_a) begin
      if (q_a.size() == 0) check("unexpected_a", q_a.size(), 1);
      else check("sum_a", sum_out_a, q_a.pop_front());
      t_a.push_back(cyc_cnt);
    end
    if (sum_valid_b) begin
      if (q_b.size() == 0) check("unexpected_b", q_b.size(), 1);
      else check("sum_b", sum_out_b, q_b.pop_front());
      t_b.push_back(cyc_cnt);
    end
  end
  task automatic run_a(input logic [1:0] sel, input logic [15:0] data, input int exp, input bit chg);
    t_a.delete();
    chan_sel = sel;
    vout_data = data;
    vs = 1'b1;
    key_a = 1'b0;
    tick();
    check("arm_busy_a", busy_a, 1);
    check("arm_vs_s_a", vs_s_a, 0);
    tick();
    vs = 1'b0;
    tick();
    check("vs_s_a", vs_s_a, 1);
    repeat (3) q_a.push_back(exp);
    if (chg) begin
      repeat (20) tick();
      chan_sel = 2'd0;
    end
    wait_for(2);
    check("done_a", done_a, 1);
    check("fcnt_a", frame_cnt_a, 3);
    check("busy_done_a", busy_a, 0);
    repeat (3) tick();
    check("hold_done_a", done_a, 1);
    check("sb_left_a", q_a.size(), 0);
    check("pulses_a", t_a.size(), 3);
    for (int i = 1; i < t_a.size(); i++) check("gap_a", t_a[i] - t_a[i-1], 16);
    key_a = 1'b1;
    tick();
    check("idle_done_a", done_a, 0);
    check("idle_vs_s_a", vs_s_a, 0);
  endtask
  initial begin
    int seen;
    rst = 1'b1;
    key_a = 1'b1;
    key_b = 1'b1;
    vs = 1'b0;
    chan_sel = 2'd0;
    vout_data = '0;
    tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    check("rst_sum", sum_out_a, 0);
    check("rst_valid", sum_valid_a, 0);
    check("rst_vs_s", vs_s_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_fcnt", frame_cnt_a, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      vs = ~vs;
      tick();
      seen += int'(busy_a | busy_b);
    end
    check("idle_busy", seen, 0);
    run_a(2'd0, {5'd5, 6'd0, 5'd2}, 15, 1'b0);
    run_a(2'd1, {5'd7, 6'd63, 5'd3}, 189, 1'b1);
    run_a(2'd3, {5'd31, 6'd63, 5'd31}, 186, 1'b0);
    t_b.delete();
    chan_sel = 2'd0;
    vout_data = {5'd5, 6'd0, 5'd0};
    vs = 1'b1;
    key_b = 1'b0;
    tick();
    tick();
    vs = 1'b0;
    tick();
    check("vs_s_b", vs_s_b, 1);
    repeat (3) q_b.push_back(15);
    for (int f = 0; f < 3; f++) begin
      repeat (4) tick();
      vs = 1'b1;
      repeat (2) tick();
      vs = 1'b0;
      repeat (2) tick();
      vs = 1'b1;
      wait_for(1);
      if (f < 2) begin
        repeat (7) tick();
        vs = 1'b0;
      end
    end
    tick();
    check("done_b", done_b, 1);
    check("fcnt_b", frame_cnt_b, 3);
    check("sb_left_b", q_b.size(), 0);
    check("pulses_b", t_b.size(), 3);
    for (int i = 1; i < t_b.size(); i++) check("gap_b", t_b[i] - t_b[i-1], 24);
    key_b = 1'b1;
    tick();
    check("idle_done_b", done_b, 0);
    check("idle_vs_s_b", vs_s_b, 0);
    chan_sel = 2'd0;
    vout_data = {5'd5, 6'd0, 5'd0};
    vs = 1'b1;
    key_a = 1'b0;
    tick();
    tick();
    vs = 1'b0;
    tick();
    q_a.push_back(15);
    wait_for(0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("abort_sum", sum_out_a, 0);
    check("abort_fcnt", frame_cnt_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_vs_s", vs_s_a, 0);
    check("abort_sb", q_a.size(), 0);
    rst = 1'b0;
    key_a = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
